// File: rtl/fb_page_streamer_if.sv
// Byte stream from the page streamer to the I2C byte transmitter.
// master = streamer side, slave = consumer side.
interface fb_page_streamer_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_first;
  logic       out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_first,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_first,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fb_page_streamer.sv
// Reads the 128x64 column frame buffer and streams SSD1306 page bytes (page-major).
// Optional vertical flip of the panel is enabled by defining FB_VFLIP_EN.
module fb_page_streamer #(
  parameter int NUM_COLS   = 128,
  parameter int NUM_PAGES  = 8,
  parameter int CONTINUOUS = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic [6:0]         fb_col_r_sel,
  input  logic [63:0]        fb_col_r_data,
  output logic               frame_done,
  fb_page_streamer_if.master stream
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_t;

  localparam logic [6:0] LAST_COL   = 7'(NUM_COLS - 1);
  localparam logic [2:0] LAST_PAGE  = 3'(NUM_PAGES - 1);
  localparam bit         AUTO_START = (CONTINUOUS != 0);

  state_t     state, state_d;
  logic [2:0] page, page_d;
  logic [6:0] col, col_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       first_q, first_d;
  logic       last_q, last_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] page_byte;
  logic       is_last;

  assign is_last = (page == LAST_PAGE) && (col == LAST_COL);

`ifdef FB_VFLIP_EN
  // Flipped panel: mirror page order and reverse the bit order inside each byte.
  logic [2:0] src_page;
  logic [7:0] raw_byte;

  always_comb begin
    src_page  = LAST_PAGE - page;
    raw_byte  = fb_col_r_data[{src_page, 3'b000} +: 8];
    page_byte = '0;
    for (int i = 0; i < 8; i++) begin
      page_byte[i] = raw_byte[7-i];
    end
  end
`else
  assign page_byte = fb_col_r_data[{page, 3'b000} +: 8];
`endif

  // col feeds the read port directly, so the address settles on entry to FETCH
  // and the registered read data is ready by the end of WAIT.
  assign fb_col_r_sel     = col;
  assign busy             = busy_q;
  assign frame_done       = done_q;
  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;
  assign stream.out_first = first_q;
  assign stream.out_last  = last_q;

  always_comb begin
    state_d = state;
    page_d  = page;
    col_d   = col;
    data_d  = data_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start || AUTO_START) begin
          page_d  = '0;
          col_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        data_d  = page_byte;
        valid_d = 1'b1;
        first_d = (page == 3'd0) && (col == 7'd0);
        last_d  = is_last;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (stream.out_ready) begin
          valid_d = 1'b0;
          first_d = 1'b0;
          last_d  = 1'b0;
          if (is_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end else begin
            if (col == LAST_COL) begin
              col_d  = '0;
              page_d = page + 3'd1;
            end else begin
              col_d = col + 7'd1;
            end
            state_d = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      page    <= '0;
      col     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_d;
      page    <= page_d;
      col     <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_page_streamer.sv
// Directed bench for fb_page_streamer: one single-shot instance and one CONTINUOUS=1 instance,
// each fed by a one-cycle-latency frame buffer model.
module tb_fb_page_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_c = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b1;
  logic        busy, busy_c, frame_done, frame_done_c;
  logic [6:0]  fb_sel, fb_sel_c;
  logic [63:0] fb_data = '0;
  logic [63:0] fb_data_c = '0;
  logic [63:0] mem [0:127];

  int errors = 0;
  int checks = 0;

  logic [7:0] got [0:1023];
  bit         got_first [0:1023];
  bit         got_last [0:1023];
  int         nbytes, done_cnt, done_cyc, last_hs_cyc, first_valid_cyc, extra, cyc;
  int         first_cnt, last_cnt;
  bit         busy_at_done, busy_c1, timeout, stall_bad, stall_seen;

  fb_page_streamer_if sif ();
  fb_page_streamer_if sifc ();

  assign sif.out_ready  = ready;
  assign sifc.out_ready = 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fb_data   <= mem[fb_sel];
    fb_data_c <= mem[fb_sel_c];
  end

  fb_page_streamer #(.NUM_COLS(128), .NUM_PAGES(8), .CONTINUOUS(0)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .fb_col_r_sel(fb_sel), .fb_col_r_data(fb_data),
    .frame_done(frame_done), .stream(sif)
  );

  fb_page_streamer #(.NUM_COLS(128), .NUM_PAGES(8), .CONTINUOUS(1)) dut_c (
    .clk(clk), .rst(rst_c), .start(1'b0), .busy(busy_c),
    .fb_col_r_sel(fb_sel_c), .fb_col_r_data(fb_data_c),
    .frame_done(frame_done_c), .stream(sifc)
  );

  // Expected byte for a column filled with {8{col}}.
  function automatic logic [7:0] exp_col_byte(input int c);
    logic [7:0] b;
    b = 8'(c);
`ifdef FB_VFLIP_EN
    exp_col_byte = {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
`else
    exp_col_byte = b;
`endif
  endfunction

  function automatic int first_bad_byte();
    first_bad_byte = -1;
    for (int n = 1023; n >= 0; n--) begin
      if (got[n] !== exp_col_byte(n % 128)) first_bad_byte = n;
    end
  endfunction

  task automatic fill_pattern();
    for (int c = 0; c < 128; c++) mem[c] = {8{8'(c)}};
  endtask

  task automatic fill_zero();
    for (int c = 0; c < 128; c++) mem[c] = '0;
  endtask

  // Drives one frame from a negedge, recording every handshake; optional stall, stray starts and reset.
  task automatic run_frame(input bit do_start, input int stall_idx, input int start_idx,
                           input bit start_in_done, input int rst_idx, input int tail);
    int         stall_cnt, since_done;
    logic [7:0] stall_data;
    bit         stop;
    for (int n = 0; n < 1024; n++) begin
      got[n] = 'x;
      got_first[n] = 1'b0;
      got_last[n] = 1'b0;
    end
    nbytes = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1;
    extra = 0; first_cnt = 0; last_cnt = 0;
    busy_at_done = 1'b1; busy_c1 = 1'b0; timeout = 1'b0; stall_bad = 1'b0; stall_seen = 1'b0;
    stall_cnt = 0; since_done = 0; stall_data = '0; stop = 1'b0;
    cyc = 0;
    start = do_start;
    ready = 1'b1;
    while (!stop) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc > 8000) begin
        timeout = 1'b1;
        stop = 1'b1;
      end else begin
        if (first_valid_cyc < 0 && sif.out_valid) first_valid_cyc = cyc;
        if (cyc == 1) busy_c1 = busy;
        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
          busy_at_done = busy;
          if (start_in_done) start = 1'b1;
        end else if (done_cnt > 0) begin
          since_done++;
          if (busy || sif.out_valid) extra++;
          if (since_done >= tail) stop = 1'b1;
        end
        if (stall_cnt > 0) begin
          stall_cnt--;
          ready = 1'b0;
          if (sif.out_valid !== 1'b1 || sif.out_data !== stall_data) stall_bad = 1'b1;
        end else if (!stall_seen && sif.out_valid && nbytes == stall_idx) begin
          stall_seen = 1'b1;
          stall_data = sif.out_data;
          stall_cnt = 9;
          ready = 1'b0;
        end else begin
          ready = 1'b1;
        end
        if (sif.out_valid && nbytes == rst_idx) begin
          rst = 1'b1;
          ready = 1'b0;
          stop = 1'b1;
        end else begin
          if (sif.out_valid && nbytes == start_idx) start = 1'b1;
          if (sif.out_valid && ready) begin
            if (nbytes < 1024) begin
              got[nbytes] = sif.out_data;
              got_first[nbytes] = sif.out_first;
              got_last[nbytes] = sif.out_last;
            end
            if (sif.out_first) first_cnt++;
            if (sif.out_last) last_cnt++;
            nbytes++;
            last_hs_cyc = cyc;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [19:0] obs;
    fill_zero();
    rst = 1'b1; start = 1'b0; ready = 1'b1;
    repeat (3) @(negedge clk);
    obs = {busy, frame_done, fb_sel, sif.out_data, sif.out_valid, sif.out_first, sif.out_last};
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h want %h", obs, 20'h0);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, sif.out_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_no_start: busy/valid got %b want 00", {busy, sif.out_valid});
    end
  endtask

  task automatic test_basic_frame();
    int bad;
    fill_pattern();
    run_frame(1'b1, -1, -1, 1'b0, -1, 3);
    checks++;
    if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got %0d want 0", timeout); end
    checks++;
    if (nbytes !== 1024) begin errors++; $display("[TB] FAIL basic_count: got %0d want 1024", nbytes); end
    bad = first_bad_byte();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL basic_bytes: byte %0d got %h want %h", bad, got[bad], exp_col_byte(bad % 128));
    end
    checks++;
    if (first_cnt !== 1 || got_first[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_first: count %0d flag0 %0d want 1 1", first_cnt, got_first[0]);
    end
    checks++;
    if (last_cnt !== 1 || got_last[1023] !== 1'b1) begin
      errors++; $display("[TB] FAIL basic_last: count %0d flag1023 %0d want 1 1", last_cnt, got_last[1023]);
    end
    checks++;
    if (first_valid_cyc !== 3) begin
      errors++; $display("[TB] FAIL first_latency: got %0d want 3", first_valid_cyc);
    end
    checks++;
    if (busy_c1 !== 1'b1) begin errors++; $display("[TB] FAIL busy_on_accept: got %0d want 1", busy_c1); end
    checks++;
    if (last_hs_cyc !== 3072) begin
      errors++; $display("[TB] FAIL throughput: last handshake cycle %0d want 3072", last_hs_cyc);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== last_hs_cyc + 1) begin
      errors++; $display("[TB] FAIL basic_done: count %0d cycle %0d want 1 %0d", done_cnt, done_cyc, last_hs_cyc + 1);
    end
    checks++;
    if (busy_at_done !== 1'b0) begin errors++; $display("[TB] FAIL busy_at_done: got %0d want 0", busy_at_done); end
    checks++;
    if (extra !== 0) begin errors++; $display("[TB] FAIL basic_idle_after: active cycles %0d want 0", extra); end
  endtask

  task automatic test_column_bits();
`ifdef FB_VFLIP_EN
    logic [7:0] want [0:7] = '{8'h80, 8'hC4, 8'hA2, 8'hE6, 8'h91, 8'hD5, 8'hB3, 8'hF7};
`else
    logic [7:0] want [0:7] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
`endif
    fill_zero();
    mem[5] = 64'h0123456789ABCDEF;
    run_frame(1'b1, -1, -1, 1'b0, -1, 1);
    for (int p = 0; p < 8; p++) begin
      checks++;
      if (got[p*128+5] !== want[p]) begin
        errors++; $display("[TB] FAIL col5_page%0d: got %h want %h", p, got[p*128+5], want[p]);
      end
    end
    checks++;
    if (got[3*128+6] !== 8'h00) begin
      errors++; $display("[TB] FAIL col6_page3: got %h want 00", got[3*128+6]);
    end
  endtask

  task automatic test_stall();
    int bad;
    fill_pattern();
    run_frame(1'b1, 200, -1, 1'b0, -1, 1);
    checks++;
    if (stall_seen !== 1'b1 || stall_bad !== 1'b0) begin
      errors++; $display("[TB] FAIL stall_hold: seen %0d unstable %0d want 1 0", stall_seen, stall_bad);
    end
    checks++;
    if (nbytes !== 1024) begin errors++; $display("[TB] FAIL stall_count: got %0d want 1024", nbytes); end
    bad = first_bad_byte();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL stall_bytes: byte %0d got %h want %h", bad, got[bad], exp_col_byte(bad % 128));
    end
    checks++;
    if (last_hs_cyc !== 3082) begin
      errors++; $display("[TB] FAIL stall_timing: last handshake cycle %0d want 3082", last_hs_cyc);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    fill_pattern();
    run_frame(1'b1, -1, 500, 1'b1, -1, 1);
    checks++;
    if (nbytes !== 1024 || done_cnt !== 1) begin
      errors++; $display("[TB] FAIL ignored_start: bytes %0d dones %0d want 1024 1", nbytes, done_cnt);
    end
    bad = first_bad_byte();
    checks++;
    if (bad !== -1) begin
      errors++;
      $display("[TB] FAIL ignored_start_bytes: byte %0d got %h want %h", bad, got[bad], exp_col_byte(bad % 128));
    end
    checks++;
    if (extra !== 0) begin errors++; $display("[TB] FAIL start_in_done: active cycles %0d want 0", extra); end
    run_frame(1'b1, -1, -1, 1'b0, -1, 1);
    checks++;
    if (first_valid_cyc !== 3 || nbytes !== 1024 || done_cnt !== 1) begin
      errors++;
      $display("[TB] FAIL restart: latency %0d bytes %0d dones %0d want 3 1024 1", first_valid_cyc, nbytes, done_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [19:0] obs;
    fill_pattern();
    run_frame(1'b1, -1, -1, 1'b0, 700, 1);
    checks++;
    if (timeout !== 1'b0 || nbytes !== 700) begin
      errors++; $display("[TB] FAIL pre_reset: timeout %0d bytes %0d want 0 700", timeout, nbytes);
    end
    @(negedge clk);
    obs = {busy, frame_done, fb_sel, sif.out_data, sif.out_valid, sif.out_first, sif.out_last};
    checks++;
    if (obs !== 20'h0) begin
      errors++; $display("[TB] FAIL mid_reset_values: got %h want %h", obs, 20'h0);
    end
    rst = 1'b0;
    run_frame(1'b1, -1, -1, 1'b0, -1, 1);
    checks++;
    if (got_first[0] !== 1'b1 || got[0] !== exp_col_byte(0) || first_valid_cyc !== 3) begin
      errors++;
      $display("[TB] FAIL after_reset_first: flag %0d byte %h latency %0d want 1 %h 3",
               got_first[0], got[0], first_valid_cyc, exp_col_byte(0));
    end
    checks++;
    if (nbytes !== 1024 || done_cnt !== 1) begin
      errors++; $display("[TB] FAIL after_reset_frame: bytes %0d dones %0d want 1024 1", nbytes, done_cnt);
    end
  endtask

  task automatic test_continuous();
    int hs, ndone, nfirst;
    int done_at [0:1];
    int first_at [0:2];
    hs = 0; ndone = 0; nfirst = 0;
    done_at = '{-1, -1};
    first_at = '{-1, -1, -1};
    fill_pattern();
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    for (int c = 0; c < 7000 && nfirst < 3; c++) begin
      @(negedge clk);
      if (frame_done_c) begin
        if (ndone < 2) done_at[ndone] = hs;
        ndone++;
      end
      if (sifc.out_valid && sifc.out_ready) begin
        if (sifc.out_first) begin
          if (nfirst < 3) first_at[nfirst] = hs;
          nfirst++;
        end
        hs++;
      end
    end
    checks++;
    if (nfirst !== 3) begin errors++; $display("[TB] FAIL cont_frames: firsts %0d want 3", nfirst); end
    checks++;
    if (done_at[0] !== 1024 || done_at[1] !== 2048) begin
      errors++; $display("[TB] FAIL cont_done: at %0d %0d want 1024 2048", done_at[0], done_at[1]);
    end
    checks++;
    if (first_at[0] !== 0 || first_at[1] !== 1024 || first_at[2] !== 2048) begin
      errors++;
      $display("[TB] FAIL cont_first: at %0d %0d %0d want 0 1024 2048", first_at[0], first_at[1], first_at[2]);
    end
  endtask

  initial begin
    fill_zero();
    test_reset();
    test_basic_frame();
    test_column_bits();
    test_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_continuous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
